// File: rtl/wb_pkg.sv
// Shared types and defaults for the write-back arbiter and its load-result queue.
// Holds the stored queue-entry layout and the register-zero constant.
package wb_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_AW     = 5;
  localparam int FIFO_DEPTH = 4;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // "reg" is a keyword, so the destination field is named dst.
  typedef struct packed {
    logic              live;
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular load-result queue with in-place squash of entries by destination register.
// The whole entry array is exported so the parent can build the pending-register mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_en,
  input  wb_entry_t               push_entry,
  input  logic                    pop_en,
  input  logic                    squash_en,
  input  logic [REG_AW-1:0]       squash_reg,
  output wb_entry_t               head,
  output logic [CW-1:0]           count,
  output wb_entry_t [DEPTH-1:0]   entries
);

  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  wb_entry_t [DEPTH-1:0]  mem_q, mem_d;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (squash_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].dst == squash_reg) mem_d[i].live = 1'b0;
      end
    end

    // A popped slot is marked dead so only occupied slots can ever contribute to the mask.
    if (pop_en) begin
      mem_d[rd_ptr_q].live = 1'b0;
      rd_ptr_d             = rd_ptr_q + PW'(1);
    end

    if (push_en) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage is reset too, because the live bits feed pendingMask straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign entries = mem_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: ALU results win outright, load results queue in wb_fifo.
// Define WB_BYPASS_EN to let a load skip the empty queue when no ALU write competes.
module writeback_arbiter #(
  parameter  int DATA_W     = wb_pkg::DATA_W,
  parameter  int REG_AW     = wb_pkg::REG_AW,
  parameter  int FIFO_DEPTH = wb_pkg::FIFO_DEPTH,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              aluValid,
  input  logic [REG_AW-1:0] aluReg,
  input  logic [DATA_W-1:0] aluData,
  input  logic              memValid,
  output logic              memReady,
  input  logic [REG_AW-1:0] memReg,
  input  logic [DATA_W-1:0] memData,
  output logic [REG_AW-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              RegWrite,
  output logic [31:0]       pendingMask,
  output logic [CW-1:0]     fifoCount
);

  import wb_pkg::*;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic                       alu_win, fifo_empty, pop_en, push_en, bypass;
  wb_entry_t                  push_entry, head;
  wb_entry_t [FIFO_DEPTH-1:0] entries;

  logic              reg_write_q, reg_write_d;
  logic [REG_AW-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  assign alu_win    = aluValid && (aluReg != REG_ZERO);
  assign fifo_empty = (fifoCount == '0);
  assign memReady   = (fifoCount < DEPTH_C);
  assign pop_en     = !alu_win && !fifo_empty;

`ifdef WB_BYPASS_EN
  assign bypass = !alu_win && fifo_empty && memValid && (memReg != REG_ZERO);
`else
  assign bypass = 1'b0;
`endif

  // Writes to x0 complete the handshake but are never stored.
  assign push_en = memValid && memReady && (memReg != REG_ZERO) && !bypass;

  // A same-cycle push counts as older than the ALU write, so it arrives already dead.
  assign push_entry.live = !(alu_win && (aluReg == memReg));
  assign push_entry.dst  = memReg;
  assign push_entry.data = memData;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .push_en    (push_en),
    .push_entry (push_entry),
    .pop_en     (pop_en),
    .squash_en  (alu_win),
    .squash_reg (aluReg),
    .head       (head),
    .count      (fifoCount),
    .entries    (entries)
  );

  always_comb begin
    pendingMask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entries[i].live) pendingMask[entries[i].dst] = 1'b1;
    end
  end

  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (alu_win) begin
      reg_write_d  = 1'b1;
      write_reg_d  = aluReg;
      write_data_d = aluData;
    end else if (pop_en) begin
      // A squashed head still pops, but only as a bubble.
      reg_write_d = head.live;
      if (head.live) begin
        write_reg_d  = head.dst;
        write_data_d = head.data;
      end
    end else if (bypass) begin
      reg_write_d  = 1'b1;
      write_reg_d  = memReg;
      write_data_d = memData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign RegWrite  = reg_write_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter; expectations are hand-computed per vector.
// Expectations for the load-only case follow WB_BYPASS_EN when it is defined.
module tb_writeback_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        aluValid;
  logic [4:0]  aluReg;
  logic [31:0] aluData;
  logic        memValid;
  logic        memReady;
  logic [4:0]  memReg;
  logic [31:0] memData;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        RegWrite;
  logic [31:0] pendingMask;
  logic [2:0]  fifoCount;

  int n_checks = 0;
  int n_pass   = 0;

  writeback_arbiter dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .aluValid    (aluValid),
    .aluReg      (aluReg),
    .aluData     (aluData),
    .memValid    (memValid),
    .memReady    (memReady),
    .memReg      (memReg),
    .memData     (memData),
    .writeReg    (writeReg),
    .writeData   (writeData),
    .RegWrite    (RegWrite),
    .pendingMask (pendingMask),
    .fifoCount   (fifoCount)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    aluValid = 1'b0; aluReg = '0; aluData = '0;
    memValid = 1'b0; memReg = '0; memData = '0;
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
    check({tag, ".we"}, 32'(RegWrite), 32'(we));
    check({tag, ".reg"}, 32'(writeReg), 32'(r));
    check({tag, ".data"}, writeData, d);
  endtask

  initial begin
    RESET_N = 1'b0;
    idle();
    step(); step();
    check_wr("rst", 1'b0, 5'd0, 32'h0);
    check("rst.count", 32'(fifoCount), 32'd0);
    check("rst.mask", pendingMask, 32'h0);
    check("rst.ready", 32'(memReady), 32'd1);
    RESET_N = 1'b1;
    step();

    // 1: single ALU write, then a bubble with held reg/data
    aluValid = 1'b1; aluReg = 5'd5; aluData = 32'hDEADBEEF;
    step();
    check_wr("t1.alu", 1'b1, 5'd5, 32'hDEADBEEF);
    idle();
    step();
    check_wr("t1.idle", 1'b0, 5'd5, 32'hDEADBEEF);

    // 2: x0 from both sources is ignored
    aluValid = 1'b1; aluReg = 5'd0; aluData = 32'h1234;
    memValid = 1'b1; memReg = 5'd0; memData = 32'h55;
    check("t2.ready", 32'(memReady), 32'd1);
    step();
    check("t2.we", 32'(RegWrite), 32'd0);
    check("t2.count", 32'(fifoCount), 32'd0);
    idle();
    step();
    check("t2.we2", 32'(RegWrite), 32'd0);

    // 3: fill queue behind ALU traffic, then drain in order
    for (int i = 0; i < 4; i++) begin
      aluValid = 1'b1; aluReg = 5'(20 + i); aluData = 32'(i);
      memValid = 1'b1; memReg = 5'(1 + i); memData = 32'hA1 + 32'(i);
      step();
      check_wr("t3.alu", 1'b1, 5'(20 + i), 32'(i));
      check("t3.count", 32'(fifoCount), 32'(i + 1));
    end
    idle();
    check("t3.ready_full", 32'(memReady), 32'd0);
    check("t3.mask_full", pendingMask, 32'h0000001E);
    for (int i = 0; i < 4; i++) begin
      step();
      check_wr("t3.drain", 1'b1, 5'(1 + i), 32'hA1 + 32'(i));
      check("t3.dcount", 32'(fifoCount), 32'(3 - i));
      check("t3.dready", 32'(memReady), 32'd1);
    end
    check("t3.mask_empty", pendingMask, 32'h0);
    step();
    check("t3.we_end", 32'(RegWrite), 32'd0);

    // 4: queued load to r7 squashed by a later ALU write to r7
    aluValid = 1'b1; aluReg = 5'd21; aluData = 32'h5;
    memValid = 1'b1; memReg = 5'd7; memData = 32'h11;
    step();
    check_wr("t4.push", 1'b1, 5'd21, 32'h5);
    check("t4.mask7", pendingMask, 32'h00000080);
    aluReg = 5'd7; aluData = 32'h22; memValid = 1'b0;
    step();
    check_wr("t4.alu7", 1'b1, 5'd7, 32'h22);
    check("t4.mask_clr", pendingMask, 32'h0);
    check("t4.count", 32'(fifoCount), 32'd1);
    idle();
    step();
    check_wr("t4.bubble", 1'b0, 5'd7, 32'h22);
    check("t4.count0", 32'(fifoCount), 32'd0);

    // 4b: push and ALU to the same register in one cycle stores a dead entry
    aluValid = 1'b1; aluReg = 5'd8; aluData = 32'h33;
    memValid = 1'b1; memReg = 5'd8; memData = 32'h44;
    step();
    check_wr("t4b.alu", 1'b1, 5'd8, 32'h33);
    check("t4b.count", 32'(fifoCount), 32'd1);
    check("t4b.mask", pendingMask, 32'h0);
    idle();
    step();
    check_wr("t4b.bubble", 1'b0, 5'd8, 32'h33);

    // 4c: simultaneous push and pop keeps the count
    aluValid = 1'b1; aluReg = 5'd22; aluData = 32'h6;
    memValid = 1'b1; memReg = 5'd10; memData = 32'hB0;
    step();
    aluValid = 1'b0; memReg = 5'd11; memData = 32'hB1;
    step();
    check_wr("t4c.pop", 1'b1, 5'd10, 32'hB0);
    check("t4c.count", 32'(fifoCount), 32'd1);
    check("t4c.mask", pendingMask, 32'h00000800);
    idle();
    step();
    check_wr("t4c.pop2", 1'b1, 5'd11, 32'hB1);
    check("t4c.count0", 32'(fifoCount), 32'd0);

    // 5: reset mid-drain discards the queue
    for (int i = 0; i < 4; i++) begin
      aluValid = 1'b1; aluReg = 5'(22 + i); aluData = 32'h0;
      memValid = 1'b1; memReg = 5'(12 + i); memData = 32'hC1 + 32'(i);
      step();
    end
    idle();
    step();
    check_wr("t5.pop", 1'b1, 5'd12, 32'hC1);
    check("t5.count3", 32'(fifoCount), 32'd3);
    #2;
    RESET_N = 1'b0;
    #1;
    check_wr("t5.rst", 1'b0, 5'd0, 32'h0);
    check("t5.count", 32'(fifoCount), 32'd0);
    check("t5.mask", pendingMask, 32'h0);
    check("t5.ready", 32'(memReady), 32'd1);
    step();
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_wr("t5.after", 1'b0, 5'd0, 32'h0);
      check("t5.acount", 32'(fifoCount), 32'd0);
    end

    // 6: lone load with empty queue and no ALU traffic
    memValid = 1'b1; memReg = 5'd9; memData = 32'h99;
    step();
    idle();
`ifdef WB_BYPASS_EN
    check_wr("t6.bypass", 1'b1, 5'd9, 32'h99);
    check("t6.count", 32'(fifoCount), 32'd0);
    step();
    check("t6.we2", 32'(RegWrite), 32'd0);
    check("t6.count2", 32'(fifoCount), 32'd0);
`else
    check("t6.we1", 32'(RegWrite), 32'd0);
    check("t6.count1", 32'(fifoCount), 32'd1);
    check("t6.mask", pendingMask, 32'h00000200);
    step();
    check_wr("t6.pop", 1'b1, 5'd9, 32'h99);
    check("t6.count2", 32'(fifoCount), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Write-back stage that directly feeds the 32x32 register file's single write port (writeReg/writeData/RegWrite).
- Merges two result sources:
  - single-cycle ALU results, which have absolute priority and no backpressure;
  - load/long-latency results, which are buffered in a small FIFO with a valid/ready handshake.
- Filters writes to x0.
- Squashes stale queued results overwritten by newer ALU writes (WAW).
- Exports a pending-register mask for the hazard unit.

Parameters:
DATA_W, 32, register data width
REG_AW, 5, register index width (32 registers)
FIFO_DEPTH, 4, load-result queue entries (power of 2, >=2)

Ports:
CLK  input  1  clock, rising edge
RESET_N  input  1  asynchronous active-low reset
aluValid  input  1  ALU result valid this cycle
aluReg  input  REG_AW  ALU destination register
aluData  input  DATA_W  ALU result
memValid  input  1  load result offered
memReady  output  1  load result accepted when memValid&&memReady
memReg  input  REG_AW  load destination register
memData  input  DATA_W  load result
writeReg  output  REG_AW  to register file
writeData  output  DATA_W  to register file
RegWrite  output  1  register-file write enable
pendingMask  output  32  bit r set while any live FIFO entry targets r
fifoCount  output  $clog2(FIFO_DEPTH)+1  occupancy, includes squashed entries

Behaviour:
- Reset (async, RESET_N=0):
  - RegWrite=0, writeReg=0, writeData=0.
  - FIFO emptied, pointers=0, fifoCount=0, pendingMask=0.
  - memReady=1 once count=0.
  - Reset mid-drain discards all queued entries, with no partial write.
- Outputs are registered. A winner selected at edge k drives RegWrite/writeReg/writeData during cycle k..k+1; the register file commits at edge k+1.
- Selection at each edge, in priority order:
  1. aluValid && aluReg!=0 -> ALU wins.
  2. Else, FIFO non-empty -> pop head. If the head is live: RegWrite=1 with its reg/data. If squashed: RegWrite=0 (bubble).
  3. Else RegWrite=0; writeReg/writeData hold their last values.
- aluValid with aluReg=0: treated as no ALU request, and the FIFO may drain that cycle.
- memReady = (fifoCount < FIFO_DEPTH), computed combinationally from registered count.
  - Push at an edge when memValid&&memReady.
  - memReg=0 is accepted (handshake completes) but not stored.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Full FIFO: memReady=0; a pop at that edge raises memReady the next cycle (no same-cycle pass-through).
- Each entry = {live, reg, data}. An ALU write to r (r!=0) clears live on every stored entry with reg==r.
- A push to r in the same cycle as an ALU write to r is stored with live=0; the same-cycle push is defined as older.
- pendingMask is combinational OR over entries with live=1.
- Latency:
  - ALU path: 1 edge.
  - Load path: 2 edges minimum (push, then pop). More if ALU traffic starves the queue.
- FIFO order is strictly preserved.

Optional Feature:
WB_BYPASS_EN
- Defined: when the FIFO is empty, no ALU winner exists, and memValid&&memReg!=0, the load result goes straight to the output registers at that edge (1-edge latency). It is not pushed, and fifoCount stays 0.
- Undefined: all load results pass through the FIFO.

Decomposition:
- Package wb_pkg:
  - DATA_W, REG_AW, FIFO_DEPTH defaults;
  - wb_entry_t packed struct {logic live; logic [REG_AW-1:0] reg; logic [DATA_W-1:0] data};
  - REG_ZERO constant.
- Sub-module wb_fifo:
  - circular buffer of wb_entry_t with push/pop, count, and a squash port (squashEn, squashReg);
  - exposes the entry array for pendingMask generation.
- The arbiter/output-register logic stays in writeback_arbiter.

Test Plan:
1. Reset, then aluValid=1, aluReg=5, aluData=0xDEADBEEF for one cycle -> next cycle RegWrite=1, writeReg=5, writeData=0xDEADBEEF; the following cycle RegWrite=0.
2. aluValid=1, aluReg=0, aluData=0x1234; mem push memReg=0 -> RegWrite never asserts, fifoCount stays 0.
3. ALU valid every cycle (regs 20..), 4 mem pushes regs 1..4 data 0xA1..0xA4 -> memReady=0 after the 4th, fifoCount=4, pendingMask=0x0000001E. Drop ALU -> writes reg1..reg4 in order on 4 consecutive cycles; memReady=1 after the first pop.
4. Push memReg=7 memData=0x11, then ALU reg 7 data 0x22 while queued -> pendingMask bit 7 clears; only 0x22 written to reg 7; the later pop gives RegWrite=0.
5. fifoCount=3 mid-drain, assert RESET_N=0 between edges -> RegWrite=0 immediately, fifoCount=0, pendingMask=0, memReady=1; no queued value ever written after release.
6. Empty FIFO, no ALU, push memReg=9 memData=0x99 -> with WB_BYPASS_EN: RegWrite=1 (writeReg=9) after 1 edge, fifoCount stays 0. Without: after 2 edges, fifoCount=1 for one cycle.
